// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for pipeline_mem_arbiter.
//   arb_state_t : arbiter FSM states (idle, serving fetch, serving data)
//   arb_src_t   : requester identity, used for the round-robin last-grant bit
//   constants   : bit values used to build all-ones byte enables and reset zeros
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } arb_src_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Replicated to the required width at the point of use.
  localparam logic MBE_BIT_ON = 1'b1;
  localparam logic RST_BIT    = 1'b0;

  // On a tie the port that was not served last wins.
  function automatic arb_src_t other_src(arb_src_t s);
    return (s == SRC_DATA) ? SRC_INST : SRC_DATA;
  endfunction

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// pipeline_mem_arbiter_if: bundles the fetch port, the data port and the
// unified memory port that pipeline_mem_arbiter sits between.
//   modport slave  : the arbiter's view (takes requests, drives the memory port)
//   modport master : the environment's view (pipeline requesters + memory)
// Parameters: ADDR_W address width, DATA_W data width (byte enables DATA_W/8).
interface pipeline_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MBE_W = DATA_W / 8;

  // Instruction-fetch port
  logic              inst_read;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_resp;

  // Data (MEM stage) port
  logic              data_read;
  logic              data_write;
  logic [MBE_W-1:0]  data_mbe;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_resp;

  // Unified memory port
  logic              mem_read;
  logic              mem_write;
  logic [MBE_W-1:0]  mem_mbe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    input  mem_rdata, mem_resp,
    output inst_rdata, inst_resp,
    output data_rdata, data_resp,
    output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    output mem_rdata, mem_resp,
    input  inst_rdata, inst_resp,
    input  data_rdata, data_resp,
    input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_req_reg.sv
// arb_req_reg: grant-time latch for the request being served by the arbiter.
// Captures address, write data, byte enables and the read/write op when load
// is high; holds them until the next grant. Asynchronous active-high reset
// clears every field.
//   clk, reset                          : clock, async active-high reset
//   load                                : capture enable (one cycle per grant)
//   in_addr, in_wdata, in_mbe, in_write : values presented at grant
//   addr, wdata, mbe, write             : latched values
module arb_req_reg #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [DATA_W/8-1:0]   in_mbe,
  input  logic                  in_write,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   mbe,
  output logic                  write
);
  import arb_pkg::*;

  localparam int unsigned MBE_W = DATA_W / 8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= {ADDR_W{RST_BIT}};
      wdata <= {DATA_W{RST_BIT}};
      mbe   <= {MBE_W{RST_BIT}};
      write <= RST_BIT;
    end else if (load) begin
      addr  <= in_addr;
      wdata <= in_wdata;
      mbe   <= in_mbe;
      write <= in_write;
    end
  end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: shares one word-wide memory port between the
// pipeline's instruction-fetch port and its data port.
// A request seen in ARB_IDLE is latched and held on the memory port until
// mem_resp; the response pulse and read data are routed to the winner in the
// mem_resp cycle. Simultaneous requests go to the data port, or, when the
// ARB_ROUND_ROBIN_EN macro is defined, to the port not granted last.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pipeline_mem_arbiter_if.slave (inst_*, data_*, mem_* signals)
module pipeline_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_mem_arbiter_if.slave  bus
);
  import arb_pkg::*;

  localparam int unsigned MBE_W = DATA_W / 8;

  arb_state_t state_q, state_d;

  logic              data_req;
  logic              tie_data;    // winner when both ports request at once
  logic              grant;
  logic              grant_data;

  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [MBE_W-1:0]  ld_mbe;
  logic              ld_write;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MBE_W-1:0]  mbe_q;
  logic              write_q;

  // A simultaneous read+write is served as a write.
  assign data_req = bus.data_read | bus.data_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_q;

  assign tie_data = (other_src(last_q) == SRC_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= SRC_INST;
    end else if (grant) begin
      last_q <= grant_data ? SRC_DATA : SRC_INST;
    end
  end
`else
  assign tie_data = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_data = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (data_req || bus.inst_read) begin
          grant      = 1'b1;
          grant_data = (data_req && bus.inst_read) ? tie_data : data_req;
          state_d    = grant_data ? ARB_DATA : ARB_INST;
        end
      end
      ARB_INST, ARB_DATA: begin
        if (bus.mem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Load values are shaped so the latch holds exactly what the memory port
  // must show: reads carry all-ones byte enables, fetches carry no write data.
  always_comb begin
    ld_write = grant_data & bus.data_write;
    ld_addr  = grant_data ? bus.data_addr : bus.inst_addr;
    ld_wdata = grant_data ? bus.data_wdata : {DATA_W{RST_BIT}};
    ld_mbe   = ld_write ? bus.data_mbe : {MBE_W{MBE_BIT_ON}};
  end

  arb_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .in_addr  (ld_addr),
    .in_wdata (ld_wdata),
    .in_mbe   (ld_mbe),
    .in_write (ld_write),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .mbe      (mbe_q),
    .write    (write_q)
  );

  // Memory port: derived only from state and latched request.
  always_comb begin
    bus.mem_read  = (state_q == ARB_INST) | ((state_q == ARB_DATA) & ~write_q);
    bus.mem_write = (state_q == ARB_DATA) & write_q;
    bus.mem_mbe   = (state_q == ARB_IDLE) ? {MBE_W{RST_BIT}} : mbe_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end

  // Requester side: completion routed to the port being served.
  always_comb begin
    bus.inst_resp  = (state_q == ARB_INST) & bus.mem_resp;
    bus.data_resp  = (state_q == ARB_DATA) & bus.mem_resp;
    bus.inst_rdata = bus.mem_rdata;
    bus.data_rdata = bus.mem_rdata;
  end

`ifndef SYNTHESIS
  a_no_read_write: assert property (@(posedge clk) disable iff (reset)
      !(bus.data_read && bus.data_write))
    else $error("pipeline_mem_arbiter: data_read and data_write both high");
`endif

endmodule
